// File: rtl/de10_slider_debounce.sv
// Slide-switch conditioner: 2-FF synchroniser, per-bit counter debounce,
// registered stable level with one-cycle per-bit change pulses.
module de10_slider_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync_a;
  logic [WIDTH-1:0] r_sync_b;
  logic [CNT_W-1:0] r_cnt      [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt  [WIDTH];
  logic [WIDTH-1:0] w_stable_nxt;
  logic [WIDTH-1:0] w_changed_nxt;

  // A single cycle of agreement drops the count back to zero.
  always_comb begin
    w_stable_nxt  = sw_stable;
    w_changed_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync_b[i] != sw_stable[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_stable_nxt[i]  = ~sw_stable[i];
          w_changed_nxt[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_a   <= '0;
      r_sync_b   <= '0;
      sw_stable  <= '0;
      sw_changed <= '0;
      any_change <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync_a   <= sw_raw;
      r_sync_b   <= r_sync_a;
      sw_stable  <= w_stable_nxt;
      sw_changed <= w_changed_nxt;
      any_change <= |w_changed_nxt;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_de10_slider_debounce.sv
// Directed bench for de10_slider_debounce with DEBOUNCE_CYCLES=8, WIDTH=10.
module tb_de10_slider_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] sw_raw = '0;
  logic [9:0] sw_stable;
  logic [9:0] sw_changed;
  logic       any_change;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] raw;
    logic [9:0] stable;
    logic [9:0] changed;
    logic       any;
  } vec_t;

  vec_t tbl [12];

  de10_slider_debounce #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sw_raw     (sw_raw),
    .sw_stable  (sw_stable),
    .sw_changed (sw_changed),
    .any_change (any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [9:0] st, input logic [9:0] ch,
                           input logic an);
    chk({name, ".stable"},  sw_stable, st);
    chk({name, ".changed"}, sw_changed, ch);
    chk({name, ".any"},     10'(any_change), 10'(an));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asserts reset, checks outputs cleared before any clock edge, releases just after an edge.
  task automatic do_reset(input logic [9:0] raw);
    sw_raw  = raw;
    reset_n = 1'b0;
    #1;
    check_all("reset", '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Bit k-1 of pat selects base|mask at edge k; expects one transition old->new at edge e (0 = none).
  task automatic run(input string name, input logic [9:0] base, input logic [9:0] mask,
                     input logic [31:0] pat, input int n, input int e,
                     input logic [9:0] old_st, input logic [9:0] new_st);
    for (int k = 1; k <= n; k++) begin
      sw_raw = pat[k-1] ? (base | mask) : base;
      step();
      if (e == 0 || k < e)
        check_all(name, old_st, '0, 1'b0);
      else if (k == e)
        check_all(name, new_st, old_st ^ new_st, 1'b1);
      else
        check_all(name, new_st, '0, 1'b0);
    end
  endtask

  initial begin
    tbl[0]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[1]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[2]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[3]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[4]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[5]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[6]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[7]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[8]  = '{10'h001, 10'h000, 10'h000, 1'b0};
    tbl[9]  = '{10'h001, 10'h001, 10'h001, 1'b1};
    tbl[10] = '{10'h001, 10'h001, 10'h000, 1'b0};
    tbl[11] = '{10'h001, 10'h001, 10'h000, 1'b0};

    #2;
    do_reset(10'h000);

    // Clean step: edge k is tbl[k-1]
    for (int k = 0; k < 12; k++) begin
      sw_raw = tbl[k].raw;
      step();
      check_all("step", tbl[k].stable, tbl[k].changed, tbl[k].any);
    end

    // Glitch on bit 3 for 5 cycles
    run("glitch", 10'h001, 10'h008, 32'h0000_001F, 15, 0, 10'h001, 10'h001);
    // Bit 4 high 7 cycles rejected, 8 cycles accepted, then falls back after release
    run("thr7", 10'h001, 10'h010, 32'h0000_007F, 15, 0, 10'h001, 10'h001);
    run("thr8", 10'h001, 10'h010, 32'h0000_00FF, 12, 10, 10'h001, 10'h011);
    run("thr8fall", 10'h001, 10'h000, 32'h0, 10, 6, 10'h011, 10'h001);
    // Bounce on bit 9: 1,0,1,1,0 then held 1 from edge 6
    run("bounce", 10'h001, 10'h200, 32'hFFFF_FFED, 18, 15, 10'h001, 10'h201);

    // Simultaneous multi-bit change
    do_reset(10'h000);
    run("simul", 10'h000, 10'h2A5, 32'hFFFF_FFFF, 12, 10, 10'h000, 10'h2A5);
    run("fall0", 10'h2A4, 10'h000, 32'h0, 12, 10, 10'h2A5, 10'h2A4);

    // Reset mid-count: 5 counting cycles, then async reset with raw held
    run("precount", 10'h001, 10'h000, 32'h0, 7, 0, 10'h2A4, 10'h2A4);
    do_reset(10'h001);
    run("postrst", 10'h001, 10'h000, 32'h0, 12, 10, 10'h000, 10'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
